shift_issue_stage: RTL and testbench

//  Elastic EX-entry stage directly upstream of the barrel shifter. Accepts decoded
//  RV32 shift ops (SLL/SRL/SRA, reg or imm shamt) from ID and registers them.

---
 rtl/shift_issue_stage_if.sv | 33 +++
 rtl/shift_issue_stage.sv | 90 +++++++++
 tb/tb_shift_issue_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_stage_if.sv
// Handshake and payload bundle between ID, the shift issue stage and the barrel shifter.
// The stage uses the slave modport; the upstream/downstream environment uses master.
interface shift_issue_stage_if #(
  parameter int unsigned TAG_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_data;
  logic [4:0]       in_shamt;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_direction;
  logic [4:0]       out_shift;
  logic [31:0]      out_fill;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_direction, out_shift, out_fill, out_tag,
           out_illegal
  );

  modport master (
    output in_valid, in_op, in_data, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_direction, out_shift, out_fill, out_tag,
           out_illegal
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Elastic EX-entry stage ahead of the barrel shifter: decodes RV32 shift ops at capture
// and holds them in a main register plus an optional one-entry skid register.
module shift_issue_stage #(
  parameter int unsigned TAG_W   = 5,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  shift_issue_stage_if.slave   bus
);

  typedef struct packed {
    logic [31:0]      data;
    logic             direction;
    logic [4:0]       shift;
    logic [31:0]      fill;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } payload_t;

  payload_t main_q, main_d, skid_q, skid_d, in_pl;
  logic     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic     accept, consume;

  // Reserved encoding 10 shifts left like SLL but is flagged illegal.
  always_comb begin
    in_pl.data      = bus.in_data;
    in_pl.direction = (bus.in_op == 2'b00) || (bus.in_op == 2'b10);
    in_pl.shift     = bus.in_shamt;
    in_pl.fill      = 32'h0;
    if (bus.in_op == 2'b11 && bus.in_data[31] && bus.in_shamt != 5'd0) begin
      in_pl.fill = ~(32'hFFFF_FFFF >> bus.in_shamt);
    end
    in_pl.tag       = bus.in_tag;
    in_pl.illegal   = (bus.in_op == 2'b10);
  end

  // Ready depends only on held state (and reset), never on in_valid.
  assign bus.in_ready = SKID_EN ? (~rst & ~skid_valid_q)
                                : (~rst & (~main_valid_q | bus.out_ready));

  assign accept  = bus.in_valid & bus.in_ready;
  assign consume = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || consume)) begin
      main_d       = in_pl;
      main_valid_d = 1'b1;
    end else if (accept && SKID_EN) begin
      skid_d       = in_pl;
      skid_valid_d = 1'b1;
    end else if (consume) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign bus.out_valid     = main_valid_q;
  assign bus.out_data      = main_q.data;
  assign bus.out_direction = main_q.direction;
  assign bus.out_shift     = main_q.shift;
  assign bus.out_fill      = main_q.fill;
  assign bus.out_tag       = main_q.tag;
  assign bus.out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: decode vector table plus backpressure,
// throughput, flush and reset sequences.
module tb_shift_issue_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  shift_issue_stage_if #(.TAG_W(5)) bus ();

  shift_issue_stage #(
    .TAG_W  (5),
    .SKID_EN(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        dir;
    logic [31:0] fill;
    logic        ill;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] data,
                       input logic [4:0] shamt, input logic [4:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_data  = data;
    bus.in_shamt = shamt;
    bus.in_tag   = tag;
  endtask

  initial begin
    vecs[0] = '{2'b11, 32'h8000_0000, 5'd4,  1'b0, 32'hF000_0000, 1'b0};
    vecs[1] = '{2'b00, 32'h0000_00F0, 5'd4,  1'b1, 32'h0000_0000, 1'b0};
    vecs[2] = '{2'b01, 32'h0000_00F0, 5'd4,  1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'b10, 32'h0000_00F0, 5'd4,  1'b1, 32'h0000_0000, 1'b1};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 5'd0,  1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{2'b11, 32'h8000_0000, 5'd31, 1'b0, 32'hFFFF_FFFE, 1'b0};
    vecs[6] = '{2'b11, 32'h7FFF_FFFF, 5'd8,  1'b0, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b11, 32'h8000_0001, 5'd1,  1'b0, 32'h8000_0000, 1'b0};
    vecs[8] = '{2'b01, 32'h8000_0000, 5'd4,  1'b0, 32'h0000_0000, 1'b0};

    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_fill", bus.out_fill, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Decode table: each op accepted, checked next cycle, then consumed
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].data, vecs[i].shamt, 5'(i + 3));
      tick();
      drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].data);
      check($sformatf("vec%0d_dir", i), 32'(bus.out_direction), 32'(vecs[i].dir));
      check($sformatf("vec%0d_shift", i), 32'(bus.out_shift), 32'(vecs[i].shamt));
      check($sformatf("vec%0d_fill", i), bus.out_fill, vecs[i].fill);
      check($sformatf("vec%0d_ill", i), 32'(bus.out_illegal), 32'(vecs[i].ill));
      check($sformatf("vec%0d_tag", i), 32'(bus.out_tag), i + 3);
    end
    tick();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: A in main, B in skid, C stalls
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'hAAAA_0001, 5'd1, 5'd1);
    tick();
    check("bp_ready_after_a", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 2'b00, 32'hBBBB_0002, 5'd2, 5'd2);
    tick();
    check("bp_ready_after_b", 32'(bus.in_ready), 32'd0);
    check("bp_hold_a", bus.out_data, 32'hAAAA_0001);
    drive(1'b1, 2'b01, 32'hCCCC_0003, 5'd3, 5'd3);
    tick();
    check("bp_still_a", bus.out_data, 32'hAAAA_0001);
    check("bp_still_a_shift", 32'(bus.out_shift), 32'd1);
    check("bp_c_stalled", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_out", bus.out_data, 32'hBBBB_0002);
    check("bp_b_tag", 32'(bus.out_tag), 32'd2);
    check("bp_ready_again", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    check("bp_c_out", bus.out_data, 32'hCCCC_0003);
    check("bp_c_dir", 32'(bus.out_direction), 32'd0);
    tick();
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Throughput: 16 back-to-back ops, one output per cycle
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b01, 32'(100 + i), 5'(i), 5'(i));
      tick();
      check($sformatf("tp%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("tp%0d_data", i), bus.out_data, 32'(100 + i));
      check($sformatf("tp%0d_ready", i), 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    tick();
    check("tp_drained", 32'(bus.out_valid), 32'd0);

    // Flush with main and skid full, new input offered
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h1111_1111, 5'd1, 5'd1);
    tick();
    drive(1'b1, 2'b00, 32'h2222_2222, 5'd2, 5'd2);
    tick();
    check("fl_full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 2'b00, 32'hDEAD_BEEF, 5'd3, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    check("fl_out_valid", 32'(bus.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("fl_nothing_emitted", 32'(bus.out_valid), 32'd0);

    // Flush overrides accept on an empty stage
    drive(1'b1, 2'b11, 32'hFFFF_0000, 5'd4, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    check("fl_drop_input", 32'(bus.out_valid), 32'd0);
    tick();
    check("fl_drop_input_late", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while holding an op
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h1234_5678, 5'd5, 5'd5);
    tick();
    check("rm_valid_before", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rm_async_valid", 32'(bus.out_valid), 32'd0);
    check("rm_async_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("rm_ready_held", 32'(bus.in_ready), 32'd0);
    check("rm_valid_held", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    rst = 1'b0;
    #1;
    check("rm_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    check("rm_no_output", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 2'b11, 32'hFFFF_FFFF, 5'd0, 5'd9);
    tick();
    drive(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    check("rm_sra0_valid", 32'(bus.out_valid), 32'd1);
    check("rm_sra0_fill", bus.out_fill, 32'h0);
    check("rm_sra0_dir", 32'(bus.out_direction), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
